obc_da_mac_seq: RTL and testbench

- Parametrised, bit-serial successor to the combinational OBC ROM-accumulate stage.
- Computes y = ±Σ A_n·x_n over N_IN two's-complement samples using offset-binary-coded distributed arithmetic.
- Consumes one bit-plane per clock, MSB first, through programmable OBC partial-sum tables, then shift-accumulates and adds a programmable offset.
- Sits between the sample buffer and the DFT output combiner; one instance per DFT bin and per real/imag part.

---
 rtl/obc_da_mac_seq_if.sv | 35 +++
 rtl/obc_da_mac_seq.sv | 153 +++++++++++++++
 tb/tb_obc_da_mac_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/obc_da_mac_seq_if.sv
// obc_da_mac_seq_if: start/result handshake, sample bus and
// partial-sum table programming port of the bit-serial OBC DA MAC.
interface obc_da_mac_seq_if #(
    parameter int N_IN   = 16,
    parameter int IN_W   = 16,
    parameter int GRP    = 4,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 52
);
    localparam int SEL_W = $clog2(N_IN / GRP) + 1;

    logic                   start;
    logic                   mode;
    logic [N_IN*IN_W-1:0]   x_in;
    logic                   busy;
    logic                   out_valid;
    logic [ACC_W-1:0]       y_out;
    logic                   tbl_we;
    logic [SEL_W-1:0]       tbl_sel;
    logic [GRP-2:0]         tbl_addr;
    logic [COEF_W-1:0]      tbl_data;
    logic                   tbl_err;

    modport master (
        output start, mode, x_in,
        output tbl_we, tbl_sel, tbl_addr, tbl_data,
        input  busy, out_valid, y_out, tbl_err
    );

    modport slave (
        input  start, mode, x_in,
        input  tbl_we, tbl_sel, tbl_addr, tbl_data,
        output busy, out_valid, y_out, tbl_err
    );
endinterface

// File: rtl/obc_da_mac_seq.sv
// obc_da_mac_seq: bit-serial offset-binary-coded distributed
// arithmetic MAC, one bit-plane per clock, MSB first.
module obc_da_mac_seq #(
    parameter int N_IN   = 16,
    parameter int IN_W   = 16,
    parameter int GRP    = 4,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 52
) (
    input logic            clk,
    input logic            rst_n,
    obc_da_mac_seq_if.slave bus
);
    localparam int NG    = N_IN / GRP;
    localparam int GW    = $clog2(NG);
    localparam int SEL_W = GW + 1;
    localparam int AW    = GRP - 1;
    localparam int DEPTH = 1 << AW;
    localparam int KW    = $clog2(IN_W);

    localparam logic [KW-1:0]    K_TOP   = KW'(IN_W - 1);
    localparam logic [SEL_W-1:0] OFS_SEL = '1;
    localparam logic [SEL_W-1:0] NG_SEL  = SEL_W'(NG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [KW-1:0]            k;
    logic [IN_W-1:0]          x_q [N_IN];
    logic                     mode_q;
    logic signed [COEF_W-1:0] tbl [NG][DEPTH];
    logic signed [COEF_W-1:0] ofs;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  psum;
    logic signed [ACC_W-1:0]  ofs_ext;
    logic signed [ACC_W-1:0]  total;
    logic [NG-1:0]            lead;
    logic [AW-1:0]            addr [NG];
    logic signed [ACC_W-1:0]  term [NG];

    logic                     accept;
    logic                     sel_ok;
    logic                     wr_ok;
    logic                     wr_bad;
    logic                     busy_q;
    logic                     valid_q;
    logic                     err_q;
    logic [ACC_W-1:0]         y_q;

    assign accept = (state == IDLE) && bus.start;
    assign sel_ok = (bus.tbl_sel < NG_SEL) || (bus.tbl_sel == OFS_SEL);
    assign wr_ok  = bus.tbl_we && (state == IDLE) && sel_ok;
    assign wr_bad = bus.tbl_we && !wr_ok;

    assign ofs_ext = {{(ACC_W-COEF_W){ofs[COEF_W-1]}}, ofs};
    assign total   = acc + ofs_ext;

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.y_out     = y_q;
    assign bus.tbl_err   = err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: RUN walks bit-planes IN_W-1 .. 0, DONE is one cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (k == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bit-plane partial sum: per group, the leading input's bit picks
    // the sign and the others (XOR the lead) address the OBC table
    always_comb begin
        psum = '0;
        lead = '0;
        addr = '{default: '0};
        term = '{default: '0};
        for (int g = 0; g < NG; g++) begin
            lead[g] = x_q[g*GRP][k];
            for (int i = 1; i < GRP; i++) begin
                addr[g][i-1] = x_q[g*GRP+i][k] ^ lead[g];
            end
            term[g] = {{(ACC_W-COEF_W){tbl[g][addr[g]][COEF_W-1]}},
                       tbl[g][addr[g]]};
            if (lead[g]) psum = psum + term[g];
            else         psum = psum - term[g];
        end
    end

    // Operand capture, shift-accumulate and result/status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            mode_q  <= 1'b0;
            acc     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= '0;
            for (int n = 0; n < N_IN; n++) x_q[n] <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= wr_bad;
            if (accept) begin
                k      <= K_TOP;
                mode_q <= bus.mode;
                busy_q <= 1'b1;
                for (int n = 0; n < N_IN; n++)
                    x_q[n] <= bus.x_in[n*IN_W +: IN_W];
            end
            if (state == RUN) begin
                k <= k - 1'b1;
                if (k == K_TOP) acc <= -psum;
                else            acc <= (acc <<< 1) + psum;
            end
            if (state == DONE) begin
                y_q     <= mode_q ? -total : total;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    // Table and offset programming, accepted only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofs <= '0;
            for (int g = 0; g < NG; g++)
                for (int a = 0; a < DEPTH; a++)
                    tbl[g][a] <= '0;
        end else if (wr_ok) begin
            if (bus.tbl_sel == OFS_SEL)
                ofs <= bus.tbl_data;
            else
                tbl[bus.tbl_sel[GW-1:0]][bus.tbl_addr] <= bus.tbl_data;
        end
    end
endmodule

// File: tb/tb_obc_da_mac_seq.sv
// tb_obc_da_mac_seq: directed vectors with hand-computed results
// for the bit-serial OBC DA MAC (A_n = 2 tables, offset -16).
module tb_obc_da_mac_seq;
    localparam int N_IN   = 16;
    localparam int IN_W   = 16;
    localparam int GRP    = 4;
    localparam int COEF_W = 32;
    localparam int ACC_W  = 52;
    localparam int NG     = N_IN / GRP;
    localparam int SEL_W  = $clog2(NG) + 1;
    localparam int AW     = GRP - 1;
    localparam int LAT    = IN_W + 2;
    localparam int XW     = N_IN * IN_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    obc_da_mac_seq_if #(
        .N_IN(N_IN), .IN_W(IN_W), .GRP(GRP),
        .COEF_W(COEF_W), .ACC_W(ACC_W)
    ) bus ();

    obc_da_mac_seq #(
        .N_IN(N_IN), .IN_W(IN_W), .GRP(GRP),
        .COEF_W(COEF_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag,
                         input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XW-1:0] fill(input int v);
        logic [XW-1:0] r;
        r = '0;
        for (int n = 0; n < N_IN; n++) r[n*IN_W +: IN_W] = IN_W'(v);
        return r;
    endfunction

    function automatic logic [XW-1:0] ramp();
        logic [XW-1:0] r;
        r = '0;
        for (int n = 0; n < N_IN; n++) r[n*IN_W +: IN_W] = IN_W'(n);
        return r;
    endfunction

    task automatic wr(input logic [SEL_W-1:0] sel,
                      input logic [AW-1:0] a,
                      input logic [COEF_W-1:0] d);
        bus.tbl_we   = 1'b1;
        bus.tbl_sel  = sel;
        bus.tbl_addr = a;
        bus.tbl_data = d;
        tick;
        bus.tbl_we   = 1'b0;
    endtask

    // Q(a) for A_n = 2: +1 for the lead, +1/-1 per address bit 0/1
    task automatic program_tables;
        logic [AW-1:0] av;
        for (int g = 0; g < NG; g++) begin
            for (int a = 0; a < (1 << AW); a++) begin
                av = AW'(a);
                wr(SEL_W'(g), av, COEF_W'(4 - 2 * $countones(av)));
            end
        end
        wr('1, '0, COEF_W'(-16));
    endtask

    task automatic wait_result(input string tag, input int lat0,
                               input longint exp_y);
        int lat;
        lat = lat0;
        while (bus.out_valid !== 1'b1 && lat < 4 * LAT) begin
            tick;
            lat++;
        end
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_y"}, $signed(bus.y_out), exp_y);
        check({tag, "_busy_lo"}, bus.busy, 0);
    endtask

    // Operands are scrambled right after the accept edge; the result
    // must come from the captured copy.
    task automatic run(input string tag, input logic [XW-1:0] xv,
                       input logic md, input longint exp_y);
        bus.x_in  = xv;
        bus.mode  = md;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.x_in  = ~xv;
        bus.mode  = ~md;
        check({tag, "_busy"}, bus.busy, 1);
        wait_result(tag, 1, exp_y);
    endtask

    initial begin
        int ov_win, bad_ov, bad_busy, bad_y;
        logic exp_ov, exp_busy;

        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.x_in     = '0;
        bus.tbl_we   = 1'b0;
        bus.tbl_sel  = '0;
        bus.tbl_addr = '0;
        bus.tbl_data = '0;

        tick;
        tick;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_y", $signed(bus.y_out), 0);
        check("rst_err", bus.tbl_err, 0);
        rst_n = 1'b1;
        tick;

        program_tables;
        check("prog_err", bus.tbl_err, 0);

        run("ones", fill(1), 1'b0, 32);
        run("neg_ones", fill(-1), 1'b0, -32);
        run("max", fill(32767), 1'b0, 1048544);
        run("min_neg", fill(-32768), 1'b1, 1048576);
        run("ramp", ramp(), 1'b0, 240);
        run("ramp_neg", ramp(), 1'b1, -240);

        // start held high: accepts at ticks 0, 18, 36
        bus.x_in = fill(1);
        bus.mode = 1'b0;
        ov_win   = 0;
        bad_ov   = 0;
        bad_busy = 0;
        bad_y    = 0;
        for (int i = 1; i <= 60; i++) begin
            bus.start = (i <= 40);
            tick;
            exp_ov   = (i % LAT == 0) && (i <= 3 * LAT);
            exp_busy = (i < 3 * LAT) && (i % LAT != 0);
            if (bus.out_valid !== exp_ov) bad_ov++;
            if (bus.busy !== exp_busy) bad_busy++;
            if (bus.out_valid === 1'b1) begin
                if ($signed(bus.y_out) != 32) bad_y++;
                if (i <= 40) ov_win++;
            end
        end
        bus.start = 1'b0;
        check("burst_results", ov_win, 2);
        check("burst_ov_timing", bad_ov, 0);
        check("burst_busy", bad_busy, 0);
        check("burst_y", bad_y, 0);

        // write attempt in RUN: rejected, result unaffected
        bus.x_in  = ramp();
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        wr('0, '0, COEF_W'(999));
        check("run_wr_err", bus.tbl_err, 1);
        wait_result("run_wr", 4, 240);

        // out-of-range group index while idle
        tick;
        wr(SEL_W'(4), '0, COEF_W'(12345));
        check("bad_sel_err", bus.tbl_err, 1);
        tick;
        check("bad_sel_err_pulse", bus.tbl_err, 0);
        run("bad_sel", ramp(), 1'b0, 240);

        // offset write and start in the same cycle: new offset used
        tick;
        bus.tbl_we   = 1'b1;
        bus.tbl_sel  = '1;
        bus.tbl_addr = '0;
        bus.tbl_data = COEF_W'(84);
        bus.x_in     = fill(1);
        bus.mode     = 1'b0;
        bus.start    = 1'b1;
        tick;
        bus.tbl_we   = 1'b0;
        bus.start    = 1'b0;
        check("wr_start_err", bus.tbl_err, 0);
        wait_result("wr_start", 1, 132);
        wr('1, '0, COEF_W'(-16));
        run("restored", fill(1), 1'b0, 32);

        // reset mid-run aborts and clears the tables
        bus.x_in  = fill(1);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.out_valid, 0);
        tick;
        rst_n = 1'b1;
        tick;
        check("abort_no_valid", bus.out_valid, 0);
        run("cleared", fill(1), 1'b0, 0);
        run("cleared_ramp", ramp(), 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
